mc_bus_bridge: RTL and testbench
================================

Name: mc_bus_bridge

Overview:
- Bridges the MCU's asynchronous parallel memory bus (mc_ce/mc_we/mc_oe, mc_add, mc_data) into the FPGA clock domain.
- Each completed write strobe becomes exactly one tagged push into the command/data input FIFO that feeds the Bus Pirate state machine.
- Read strobes return a status word or pop the output FIFO.
- Sits directly upstream of the input FIFO and BPSM in top; all MCU transactions pass through it.

Parameters:
MC_DATA_WIDTH, 16, width of mc_data and FIFO words
MC_ADD_WIDTH, 6, width of mc_add
SYNC_STAGES, 2, flip-flop stages in strobe synchronisers (legal values 2..3)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
mc_ce  in  1  chip enable, active low
mc_we  in  1  write strobe, active low
mc_oe  in  1  read strobe, active low
mc_add  in  MC_ADD_WIDTH  register address
mc_data  inout  MC_DATA_WIDTH  bidirectional data bus
in_data  out  MC_DATA_WIDTH  word to input FIFO
in_is_cmd  out  1  1 = command word (address 0x01), 0 = data word (address 0x00)
in_push  out  1  one-cycle push strobe to input FIFO
in_full  in  1  input FIFO full
out_data  in  MC_DATA_WIDTH  output FIFO head (first-word-fall-through)
out_nempty  in  1  output FIFO not empty
out_pop  out  1  one-cycle pop strobe to output FIFO
bp_active  in  1  BPSM busy, reported in status

Behaviour:
- Reset (reset=0, async):
  - in_push, out_pop, in_is_cmd, in_data and sticky flags clear to 0.
  - Synchroniser stages for ce/we/oe preset to 1 (idle), so no edge is seen on release.
  - mc_data is tristated.
- Synchronisation: ce_s, we_s and oe_s are SYNC_STAGES-FF synchronised copies of the pins. All edge detection uses the previous-cycle copy.
- Address map:
  - 0x00 write: data push.
  - 0x01 write: command push.
  - 0x02 read: status.
  - 0x03 read: output FIFO word plus pop.
  - Any other address: writes ignored; reads return 0.
- Write capture:
  - While we_s=0 and ce_s=0, mc_add and mc_data are registered every cycle.
  - A write is armed on the falling edge of we_s with ce_s=0.
  - It completes on the rising edge of we_s.
  - If ce_s rises while armed, the write is aborted and no push occurs.
- Write commit: on the completion cycle +1, for address 0x00/0x01:
  - in_push=1 for exactly 1 cycle.
  - in_data = captured data; in_is_cmd = captured address[0].
  - If in_full=1 at commit, there is no push and sticky OVF is set.
- Latency: in_push rises SYNC_STAGES+1 clocks after the first posedge that samples mc_we=1.
- Bus timing: mc_add/mc_data must be stable from 1 clock before mc_we falls until SYNC_STAGES+1 clocks after mc_we rises.
- Read drive:
  - mc_data is driven whenever raw mc_oe=0, mc_ce=0 and mc_we=1; otherwise it is Z.
  - The driven value is a register updated every cycle while oe_s=0.
- Status word (address 0x02):
  - bit0 in_full, bit1 out_nempty, bit2 bp_active, bit3 OVF, bit4 UNF, bit5 PERR.
  - Upper bits are 0.
- Read completion: rising edge of oe_s with ce_s=0.
  - Address 0x03 with out_nempty=1: out_pop=1 for 1 cycle, on the cycle after the edge.
  - Address 0x03 with out_nempty=0: returns 0, no pop, sets UNF.
  - Address 0x02: clears OVF, UNF and PERR on completion. A flag event in the same cycle wins, so that flag stays set.
- Protocol error: if we_s=0 and oe_s=0 in the same cycle:
  - Sets PERR.
  - Disarms any pending write.
  - Suppresses push and pop for that transaction.
  - mc_data is not driven.
- Back-to-back: a new strobe may begin the cycle after commit. At most one push or pop per transaction, never both.
- Reset mid-transaction: the transaction is discarded and no strobe is emitted after release.

Test Plan:
- Write 0x01 ← 0xFD00, then 0x00 ← 0x0005, using 3/6/3-cycle strobe timing → two single-cycle in_push: (in_is_cmd=1, in_data=0xFD00) then (0, 0x0005); latency SYNC_STAGES+1 after mc_we rises.
- Hold in_full=1 and write 0x00 ← 0x1234 → no in_push. A status read returns bit3=1; a second status read returns bit3=0.
- out_nempty=1, out_data=0xBEEF; read address 0x03 → mc_data=0xBEEF while mc_oe=0, one out_pop after the strobe. Repeat with out_nempty=0 → mc_data=0x0000, no pop, UNF set.
- mc_ce raised mid write strobe → no in_push; mc_data stays Z throughout.
- mc_we and mc_oe low together for 4 cycles → no push/pop, mc_data Z, PERR set in the next status read.
- Assert reset during the mc_we-low phase and release it before mc_we rises → no in_push; all outputs 0; next normal write pushes correctly.

Source files
------------

// File: rtl/mc_bus_bridge.sv
// Bridges the MCU asynchronous parallel bus into clock: synchronised strobes drive tagged input-FIFO
// pushes, status reads and output-FIFO pops.
//   state     | meaning
//   WR_IDLE   | no write in flight
//   WR_ARMED  | we_s fell with ce_s low; address/data being captured
//   WR_COMMIT | we_s rose cleanly; push (or flag OVF) this cycle
module mc_bus_bridge #(
    parameter int MC_DATA_WIDTH = 16,
    parameter int MC_ADD_WIDTH  = 6,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mc_ce,
    input  logic                     mc_we,
    input  logic                     mc_oe,
    input  logic [MC_ADD_WIDTH-1:0]  mc_add,
    inout  wire  [MC_DATA_WIDTH-1:0] mc_data,
    output logic [MC_DATA_WIDTH-1:0] in_data,
    output logic                     in_is_cmd,
    output logic                     in_push,
    input  logic                     in_full,
    input  logic [MC_DATA_WIDTH-1:0] out_data,
    input  logic                     out_nempty,
    output logic                     out_pop,
    input  logic                     bp_active
);

    typedef enum logic [1:0] {WR_IDLE, WR_ARMED, WR_COMMIT} wr_state_t;

    wr_state_t                wr_state_q, wr_state_d;
    logic [SYNC_STAGES-1:0]   ce_sync_q, we_sync_q, oe_sync_q;
    logic [SYNC_STAGES:0]     vld_q;
    logic                     we_p_q, oe_p_q;
    logic [MC_ADD_WIDTH-1:0]  cap_add_q, rd_add_q;
    logic [MC_DATA_WIDTH-1:0] cap_data_q, rd_data_q, rd_word;
    logic [MC_DATA_WIDTH-1:0] in_data_q, in_data_d;
    logic                     in_is_cmd_q, in_is_cmd_d;
    logic                     in_push_q, in_push_d;
    logic                     out_pop_q, out_pop_d;
    logic                     rd_armed_q, rd_armed_d;
    logic                     ovf_q, ovf_d, unf_q, unf_d, perr_q, perr_d;
    logic                     ce_s, we_s, oe_s, sync_ok;
    logic                     we_fall, we_rise, oe_fall, oe_rise, perr_ev;
    logic                     rd_done, stat_clr, ovf_set, unf_set, wr_add_ok;

    assign ce_s    = ce_sync_q[SYNC_STAGES-1];
    assign we_s    = we_sync_q[SYNC_STAGES-1];
    assign oe_s    = oe_sync_q[SYNC_STAGES-1];
    // Edges only count once the preset synchroniser contents have been flushed by real pin samples,
    // so a strobe already low when reset releases is never taken as a new transaction.
    assign sync_ok = vld_q[SYNC_STAGES];

    assign we_fall = we_p_q & ~we_s;
    assign we_rise = we_s & ~we_p_q;
    assign oe_fall = oe_p_q & ~oe_s;
    assign oe_rise = oe_s & ~oe_p_q;
    assign perr_ev = ~we_s & ~oe_s;

    assign wr_add_ok = (cap_add_q[MC_ADD_WIDTH-1:1] == '0);
    assign rd_done   = rd_armed_q & oe_rise & ~ce_s;
    assign stat_clr  = rd_done & (rd_add_q == MC_ADD_WIDTH'(2));
    assign unf_set   = rd_done & (rd_add_q == MC_ADD_WIDTH'(3)) & ~out_nempty;

    always_comb begin
        rd_word = '0;
        case (mc_add)
            MC_ADD_WIDTH'(2): rd_word = MC_DATA_WIDTH'({perr_q, unf_q, ovf_q, bp_active, out_nempty, in_full});
            MC_ADD_WIDTH'(3): rd_word = out_nempty ? out_data : '0;
            default:          rd_word = '0;
        endcase
    end

    always_comb begin
        wr_state_d  = wr_state_q;
        in_push_d   = 1'b0;
        in_data_d   = in_data_q;
        in_is_cmd_d = in_is_cmd_q;
        ovf_set     = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (we_fall && !ce_s && sync_ok && !perr_ev) wr_state_d = WR_ARMED;
            end
            WR_ARMED: begin
                if (perr_ev || ce_s)  wr_state_d = WR_IDLE;
                else if (we_rise)     wr_state_d = wr_add_ok ? WR_COMMIT : WR_IDLE;
            end
            WR_COMMIT: begin
                if (in_full) begin
                    ovf_set = 1'b1;
                end else begin
                    in_push_d   = 1'b1;
                    in_data_d   = cap_data_q;
                    in_is_cmd_d = cap_add_q[0];
                end
                wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase

        rd_armed_d = rd_armed_q;
        if (oe_fall && !ce_s && sync_ok) rd_armed_d = 1'b1;
        if (oe_rise)                     rd_armed_d = 1'b0;
        if (perr_ev)                     rd_armed_d = 1'b0;

        out_pop_d = rd_done & (rd_add_q == MC_ADD_WIDTH'(3)) & out_nempty;

        // A set event in the clearing cycle wins, so the flag is never lost.
        ovf_d  = (ovf_q  & ~stat_clr) | ovf_set;
        unf_d  = (unf_q  & ~stat_clr) | unf_set;
        perr_d = (perr_q & ~stat_clr) | perr_ev;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ce_sync_q <= '1;
            we_sync_q <= '1;
            oe_sync_q <= '1;
            we_p_q    <= 1'b1;
            oe_p_q    <= 1'b1;
            vld_q     <= '0;
        end else begin
            ce_sync_q <= {ce_sync_q[SYNC_STAGES-2:0], mc_ce};
            we_sync_q <= {we_sync_q[SYNC_STAGES-2:0], mc_we};
            oe_sync_q <= {oe_sync_q[SYNC_STAGES-2:0], mc_oe};
            we_p_q    <= we_s;
            oe_p_q    <= oe_s;
            vld_q     <= {vld_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_state_q  <= WR_IDLE;
            cap_add_q   <= '0;
            cap_data_q  <= '0;
            rd_add_q    <= '0;
            rd_data_q   <= '0;
            in_data_q   <= '0;
            in_is_cmd_q <= 1'b0;
            in_push_q   <= 1'b0;
            out_pop_q   <= 1'b0;
            rd_armed_q  <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            if (!we_s && !ce_s) begin
                cap_add_q  <= mc_add;
                cap_data_q <= mc_data;
            end
            if (!oe_s) begin
                rd_add_q  <= mc_add;
                rd_data_q <= rd_word;
            end
            in_data_q   <= in_data_d;
            in_is_cmd_q <= in_is_cmd_d;
            in_push_q   <= in_push_d;
            out_pop_q   <= out_pop_d;
            rd_armed_q  <= rd_armed_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            perr_q      <= perr_d;
        end
    end

    // Drive follows the raw pins so the bus turns around without synchroniser delay.
    assign mc_data = (reset && !mc_oe && !mc_ce && mc_we) ? rd_data_q : {MC_DATA_WIDTH{1'bz}};

    assign in_data   = in_data_q;
    assign in_is_cmd = in_is_cmd_q;
    assign in_push   = in_push_q;
    assign out_pop   = out_pop_q;

endmodule

// File: tb/tb_mc_bus_bridge.sv
// Directed bench for mc_bus_bridge: writes, overflow, output reads, abort, protocol error, reset mid-write.
// mc_data carries a pull-up so an undriven bus reads as all ones.
module tb_mc_bus_bridge;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int SS = 2;
    localparam logic [DW-1:0] BUS_Z = 16'hFFFF;
    // Count of negedges from raising mc_we to seeing in_push: 1 sampling edge plus SS+1 clocks.
    localparam int EXP_LAT = SS + 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          mc_ce = 1'b1;
    logic          mc_we = 1'b1;
    logic          mc_oe = 1'b1;
    logic [AW-1:0] mc_add = '0;
    tri1  [DW-1:0] mc_data;
    logic          tb_drv = 1'b0;
    logic [DW-1:0] tb_dout = '0;
    logic [DW-1:0] in_data;
    logic          in_is_cmd, in_push, out_pop;
    logic          in_full = 1'b0;
    logic [DW-1:0] out_data = '0;
    logic          out_nempty = 1'b0;
    logic          bp_active = 1'b0;

    int checks = 0;
    int errors = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    logic [DW-1:0] last_data = '0;
    logic          last_cmd = 1'b0;

    assign mc_data = tb_drv ? tb_dout : {DW{1'bz}};

    mc_bus_bridge #(.MC_DATA_WIDTH(DW), .MC_ADD_WIDTH(AW), .SYNC_STAGES(SS)) dut (
        .clock(clock), .reset(reset), .mc_ce(mc_ce), .mc_we(mc_we), .mc_oe(mc_oe),
        .mc_add(mc_add), .mc_data(mc_data), .in_data(in_data), .in_is_cmd(in_is_cmd),
        .in_push(in_push), .in_full(in_full), .out_data(out_data), .out_nempty(out_nempty),
        .out_pop(out_pop), .bp_active(bp_active)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (in_push === 1'b1) begin
            push_cnt++;
            last_data = in_data;
            last_cmd  = in_is_cmd;
        end
        if (out_pop === 1'b1) pop_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
        @(negedge clock);
        mc_add = a; tb_dout = d; tb_drv = 1'b1; mc_ce = 1'b0;
        repeat (3) @(negedge clock);
        mc_we = 1'b0;
        repeat (6) @(negedge clock);
        mc_we = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (in_push === 1'b1 && lat == 0) lat = k;
        end
        mc_ce = 1'b1; tb_drv = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] v);
        @(negedge clock);
        mc_add = a; tb_drv = 1'b0; mc_ce = 1'b0;
        repeat (2) @(negedge clock);
        mc_oe = 1'b0;
        repeat (5) @(negedge clock);
        v = mc_data;
        mc_oe = 1'b1;
        repeat (5) @(negedge clock);
        mc_ce = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++; if (in_push !== 1'b0) begin errors++; $display("FAIL rst_push got %b exp 0", in_push); end
        checks++; if (out_pop !== 1'b0) begin errors++; $display("FAIL rst_pop got %b exp 0", out_pop); end
        checks++; if (in_data !== 16'h0000) begin errors++; $display("FAIL rst_data got %h exp 0000", in_data); end
        checks++; if (in_is_cmd !== 1'b0) begin errors++; $display("FAIL rst_cmd got %b exp 0", in_is_cmd); end
        checks++; if (mc_data !== BUS_Z) begin errors++; $display("FAIL rst_bus got %h exp %h", mc_data, BUS_Z); end
        reset = 1'b1;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_status_idle();
        logic [DW-1:0] v;
        out_nempty = 1'b1; bp_active = 1'b1;
        bus_read(6'h02, v);
        checks++; if (v !== 16'h0006) begin errors++; $display("FAIL status_idle got %h exp 0006", v); end
        out_nempty = 1'b0; bp_active = 1'b0;
    endtask

    task automatic test_write();
        int lat, p;
        p = push_cnt;
        bus_write(6'h01, 16'hFD00, lat);
        checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL wr1_lat got %0d exp %0d", lat, EXP_LAT); end
        checks++; if (push_cnt - p != 1) begin errors++; $display("FAIL wr1_pushes got %0d exp 1", push_cnt - p); end
        checks++; if (last_cmd !== 1'b1) begin errors++; $display("FAIL wr1_cmd got %b exp 1", last_cmd); end
        checks++; if (last_data !== 16'hFD00) begin errors++; $display("FAIL wr1_data got %h exp FD00", last_data); end
        p = push_cnt;
        bus_write(6'h00, 16'h0005, lat);
        checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL wr2_lat got %0d exp %0d", lat, EXP_LAT); end
        checks++; if (push_cnt - p != 1) begin errors++; $display("FAIL wr2_pushes got %0d exp 1", push_cnt - p); end
        checks++; if (last_cmd !== 1'b0) begin errors++; $display("FAIL wr2_cmd got %b exp 0", last_cmd); end
        checks++; if (last_data !== 16'h0005) begin errors++; $display("FAIL wr2_data got %h exp 0005", last_data); end
    endtask

    task automatic test_overflow();
        int lat, p;
        logic [DW-1:0] v;
        in_full = 1'b1;
        p = push_cnt;
        bus_write(6'h00, 16'h1234, lat);
        checks++; if (push_cnt - p != 0) begin errors++; $display("FAIL ovf_pushes got %0d exp 0", push_cnt - p); end
        checks++; if (in_data !== 16'h0005) begin errors++; $display("FAIL ovf_data_held got %h exp 0005", in_data); end
        bus_read(6'h02, v);
        checks++; if (v !== 16'h0009) begin errors++; $display("FAIL ovf_status1 got %h exp 0009", v); end
        bus_read(6'h02, v);
        checks++; if (v !== 16'h0001) begin errors++; $display("FAIL ovf_status2 got %h exp 0001", v); end
        in_full = 1'b0;
    endtask

    task automatic test_out_read();
        int p;
        logic [DW-1:0] v;
        out_nempty = 1'b1; out_data = 16'hBEEF;
        p = pop_cnt;
        bus_read(6'h03, v);
        checks++; if (v !== 16'hBEEF) begin errors++; $display("FAIL rd_word got %h exp BEEF", v); end
        checks++; if (pop_cnt - p != 1) begin errors++; $display("FAIL rd_pops got %0d exp 1", pop_cnt - p); end
        out_nempty = 1'b0;
        p = pop_cnt;
        bus_read(6'h03, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL unf_word got %h exp 0000", v); end
        checks++; if (pop_cnt - p != 0) begin errors++; $display("FAIL unf_pops got %0d exp 0", pop_cnt - p); end
        bus_read(6'h02, v);
        checks++; if (v !== 16'h0010) begin errors++; $display("FAIL unf_status got %h exp 0010", v); end
        bus_read(6'h02, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL unf_cleared got %h exp 0000", v); end
        checks++; if (mc_data !== BUS_Z) begin errors++; $display("FAIL rd_release got %h exp %h", mc_data, BUS_Z); end
    endtask

    task automatic test_abort();
        int p, zbad;
        p = push_cnt; zbad = 0;
        @(negedge clock);
        mc_add = 6'h00; tb_drv = 1'b0; mc_ce = 1'b0;
        repeat (3) @(negedge clock);
        mc_we = 1'b0;
        for (int k = 0; k < 4; k++) begin @(negedge clock); if (mc_data !== BUS_Z) zbad++; end
        mc_ce = 1'b1;
        for (int k = 0; k < 3; k++) begin @(negedge clock); if (mc_data !== BUS_Z) zbad++; end
        mc_we = 1'b1;
        for (int k = 0; k < 8; k++) begin @(negedge clock); if (mc_data !== BUS_Z) zbad++; end
        checks++; if (push_cnt - p != 0) begin errors++; $display("FAIL abort_pushes got %0d exp 0", push_cnt - p); end
        checks++; if (zbad != 0) begin errors++; $display("FAIL abort_bus_driven got %0d cycles exp 0", zbad); end
    endtask

    task automatic test_proto_error(input logic [AW-1:0] a);
        int p, q, zbad;
        logic [DW-1:0] v;
        p = push_cnt; q = pop_cnt; zbad = 0;
        out_nempty = 1'b1; out_data = 16'hCAFE;
        @(negedge clock);
        mc_add = a; tb_drv = 1'b0; mc_ce = 1'b0;
        repeat (3) @(negedge clock);
        mc_we = 1'b0; mc_oe = 1'b0;
        for (int k = 0; k < 4; k++) begin @(negedge clock); if (mc_data !== BUS_Z) zbad++; end
        mc_we = 1'b1; mc_oe = 1'b1;
        for (int k = 0; k < 8; k++) begin @(negedge clock); if (mc_data !== BUS_Z) zbad++; end
        mc_ce = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (push_cnt - p != 0) begin errors++; $display("FAIL perr_pushes a=%h got %0d exp 0", a, push_cnt - p); end
        checks++; if (pop_cnt - q != 0) begin errors++; $display("FAIL perr_pops a=%h got %0d exp 0", a, pop_cnt - q); end
        checks++; if (zbad != 0) begin errors++; $display("FAIL perr_bus_driven a=%h got %0d exp 0", a, zbad); end
        out_nempty = 1'b0; bp_active = 1'b1;
        bus_read(6'h02, v);
        checks++; if (v !== 16'h0024) begin errors++; $display("FAIL perr_status a=%h got %h exp 0024", a, v); end
        bus_read(6'h02, v);
        checks++; if (v !== 16'h0004) begin errors++; $display("FAIL perr_cleared a=%h got %h exp 0004", a, v); end
        bp_active = 1'b0;
    endtask

    task automatic test_reset_mid();
        int p, lat;
        p = push_cnt;
        @(negedge clock);
        mc_add = 6'h01; tb_dout = 16'h5A5A; tb_drv = 1'b1; mc_ce = 1'b0;
        repeat (3) @(negedge clock);
        mc_we = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (in_push !== 1'b0) begin errors++; $display("FAIL midrst_push got %b exp 0", in_push); end
        checks++; if (out_pop !== 1'b0) begin errors++; $display("FAIL midrst_pop got %b exp 0", out_pop); end
        checks++; if (in_data !== 16'h0000) begin errors++; $display("FAIL midrst_data got %h exp 0000", in_data); end
        checks++; if (in_is_cmd !== 1'b0) begin errors++; $display("FAIL midrst_cmd got %b exp 0", in_is_cmd); end
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        mc_we = 1'b1;
        repeat (8) @(negedge clock);
        mc_ce = 1'b1; tb_drv = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (push_cnt - p != 0) begin errors++; $display("FAIL midrst_pushes got %0d exp 0", push_cnt - p); end
        p = push_cnt;
        bus_write(6'h01, 16'h00A5, lat);
        checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL postrst_lat got %0d exp %0d", lat, EXP_LAT); end
        checks++; if (push_cnt - p != 1) begin errors++; $display("FAIL postrst_pushes got %0d exp 1", push_cnt - p); end
        checks++; if (last_cmd !== 1'b1) begin errors++; $display("FAIL postrst_cmd got %b exp 1", last_cmd); end
        checks++; if (last_data !== 16'h00A5) begin errors++; $display("FAIL postrst_data got %h exp 00A5", last_data); end
    endtask

    initial begin
        test_reset();
        test_status_idle();
        test_write();
        test_overflow();
        test_out_read();
        test_abort();
        test_proto_error(6'h03);
        test_proto_error(6'h00);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
